calc_result_arbiter: RTL

Round-robin scheduler that shares the calculator's 32-bit, 16:1 one-hot result multiplexer among 16 function units.
- Picks one requesting unit and drives the mux's one-hot `hotselect`.
- Captures the mux output one cycle later and acknowledges the unit.
- Presents the captured result on a valid/ready output toward the host/middleware interface.
- Sits between the function units and the host-facing result register; the mux itself stays external.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_result_arbiter_if.sv | 37 +++
 rtl/calc_result_arbiter_rr_pick.sv | 32 +++
 rtl/calc_result_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result path arbiter and its
// reusable rotate-priority picker.
package calc_pkg;

    localparam int N_REQ  = 16;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        OUT  = 2'd2
    } arb_state_t;

    typedef logic [N_REQ-1:0]  sel_vec_t;
    typedef logic [DATA_W-1:0] data_word_t;
    typedef logic [SRC_W-1:0]  src_idx_t;

    // Successor of a unit index, wrapping from the last unit back to unit 0.
    function automatic src_idx_t wrap_inc(input src_idx_t idx);
        src_idx_t nxt;
        if (idx == src_idx_t'(N_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + src_idx_t'(1'b1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/calc_result_arbiter_if.sv
// Bundle of the function-unit handshake, result-mux select/data and the
// host-facing valid/ready result channel.
interface calc_result_arbiter_if;
    import calc_pkg::*;

    sel_vec_t   req;
    sel_vec_t   ack;
    sel_vec_t   hotselect;
    data_word_t muxout;
    logic       out_valid;
    data_word_t out_data;
    src_idx_t   out_src;
    logic       out_ready;

    modport master (
        input  req,
        input  muxout,
        input  out_ready,
        output ack,
        output hotselect,
        output out_valid,
        output out_data,
        output out_src
    );

    modport slave (
        output req,
        output muxout,
        output out_ready,
        input  ack,
        input  hotselect,
        input  out_valid,
        input  out_data,
        input  out_src
    );

endinterface

// File: rtl/calc_result_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or above the
// pointer, wrapping past the top index back to zero.
module rr_pick
    import calc_pkg::*;
(
    input  sel_vec_t req_i,
    input  src_idx_t rr_ptr_i,
    output logic     any_o,
    output sel_vec_t grant_o,
    output src_idx_t idx_o
);

    // Walk from the farthest offset down so the nearest request wins last.
    always_comb begin
        src_idx_t pos_s;
        any_o   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        pos_s   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos_s = src_idx_t'((int'(rr_ptr_i) + k) % N_REQ);
            if (req_i[pos_s]) begin
                any_o   = 1'b1;
                grant_o = sel_vec_t'(1'b1) << pos_s;
                idx_o   = pos_s;
            end else begin
                grant_o = grant_o;
            end
        end
    end

endmodule

// File: rtl/calc_result_arbiter.sv
// Round-robin owner of the 16:1 result mux: select a unit, capture the mux
// one cycle later, acknowledge it, and hold the result until the host takes it.
module calc_result_arbiter
    import calc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    calc_result_arbiter_if.master bus
);

    arb_state_t state_q,     state_d;
    src_idx_t   rr_ptr_q,    rr_ptr_d;
    src_idx_t   win_idx_q,   win_idx_d;
    sel_vec_t   hotselect_q, hotselect_d;
    sel_vec_t   ack_q,       ack_d;
    logic       out_valid_q, out_valid_d;
    data_word_t out_data_q,  out_data_d;
    src_idx_t   out_src_q,   out_src_d;

    logic       pick_any_s;
    sel_vec_t   pick_grant_s;
    src_idx_t   pick_idx_s;

    rr_pick u_rr_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (pick_any_s),
        .grant_o  (pick_grant_s),
        .idx_o    (pick_idx_s)
    );

    // Next-state and output decode; select and ack are only ever live in SEL.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_idx_d   = win_idx_q;
        hotselect_d = '0;
        ack_d       = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    hotselect_d = pick_grant_s;
                    ack_d       = pick_grant_s;
                    win_idx_d   = pick_idx_s;
                    state_d     = SEL;
                end else begin
                    state_d     = IDLE;
                end
            end
            SEL: begin
                out_data_d  = bus.muxout;
                out_src_d   = win_idx_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                // Requests are not looked at here; the next IDLE cycle decides.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    rr_ptr_d    = wrap_inc(win_idx_q);
                    state_d     = IDLE;
                end else begin
                    state_d     = OUT;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_idx_q   <= '0;
            hotselect_q <= '0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_idx_q   <= win_idx_d;
            hotselect_q <= hotselect_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.hotselect = hotselect_q;
    assign bus.ack       = ack_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule
